// File: rtl/time_display.sv
// Display end of the game countdown timer. It converts the seconds count to BCD,
// scans four multiplexed 7-segment digits and blinks the display after a timeout.
module time_display #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_DIV    = 25000000,
  parameter int BLINK_PHASES = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] counter,
  input  logic        time_out,
  output logic [15:0] bcd,
  output logic        busy,
  output logic [3:0]  an,
  output logic [6:0]  sseg,
  output logic        dp
);

  // state   | meaning
  // IDLE    | waiting for counter to differ from the last converted value
  // CONVERT | one shift-add-3 iteration per cycle, 12 in total
  // LOAD    | publish the finished BCD word and release busy
  typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int PW = $clog2(BLINK_PHASES + 1);
  localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [PW-1:0] PH_INIT    = PW'(BLINK_PHASES);

  state_t      state, state_nxt;
  logic [27:0] shift_reg, shift_nxt;
  logic [3:0]  iter, iter_nxt;
  logic [11:0] last_val, last_nxt;
  logic [15:0] bcd_nxt;
  logic        busy_nxt;

  function automatic logic [27:0] dabble_step(input logic [27:0] s);
    logic [27:0] t;
    t = s;
    for (int i = 0; i < 4; i++) begin
      if (t[12+4*i +: 4] >= 4'd5)
        t[12+4*i +: 4] = t[12+4*i +: 4] + 4'd3;
    end
    return {t[26:0], 1'b0};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      iter      <= '0;
      last_val  <= '0;
      bcd       <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      iter      <= iter_nxt;
      last_val  <= last_nxt;
      bcd       <= bcd_nxt;
      busy      <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shift_nxt = shift_reg;
    iter_nxt  = iter;
    last_nxt  = last_val;
    bcd_nxt   = bcd;
    busy_nxt  = busy;
    case (state)
      IDLE: begin
        if (counter != last_val) begin
          shift_nxt = {16'b0, counter};
          last_nxt  = counter;
          iter_nxt  = '0;
          busy_nxt  = 1'b1;
          state_nxt = CONVERT;
        end
      end
      CONVERT: begin
        shift_nxt = dabble_step(shift_reg);
        iter_nxt  = iter + 4'd1;
        if (iter == 4'd11)
          state_nxt = LOAD;
      end
      LOAD: begin
        bcd_nxt   = shift_reg[27:12];
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  logic [RW-1:0] refresh_cnt;
  logic [1:0]    digit_idx, idx_nxt;
  logic          ref_wrap;

  assign ref_wrap = (refresh_cnt == REF_LAST);
  assign idx_nxt  = ref_wrap ? digit_idx + 2'd1 : digit_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else begin
      refresh_cnt <= ref_wrap ? '0 : refresh_cnt + RW'(1);
      digit_idx   <= idx_nxt;
    end
  end

  logic          time_out_d, to_rise;
  logic [BW-1:0] blink_cnt, blink_cnt_nxt;
  logic          phase, phase_nxt;
  logic [PW-1:0] phases_left, phases_left_nxt;
  logic          dark_nxt;

  assign to_rise = time_out & ~time_out_d;

  always_comb begin
    blink_cnt_nxt   = blink_cnt;
    phase_nxt       = phase;
    phases_left_nxt = phases_left;
    if (to_rise) begin
      blink_cnt_nxt   = '0;
      phase_nxt       = 1'b0;
      phases_left_nxt = PH_INIT;
    end else if (phases_left != '0) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt_nxt   = '0;
        phase_nxt       = ~phase;
        phases_left_nxt = phases_left - PW'(1);
      end else begin
        blink_cnt_nxt = blink_cnt + BW'(1);
      end
    end
  end

  // Dark is decided from next-state so the display blanks on the detect edge.
  assign dark_nxt = (phases_left_nxt != '0) && !phase_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      time_out_d  <= 1'b0;
      blink_cnt   <= '0;
      phase       <= 1'b0;
      phases_left <= '0;
    end else begin
      time_out_d  <= time_out;
      blink_cnt   <= blink_cnt_nxt;
      phase       <= phase_nxt;
      phases_left <= phases_left_nxt;
    end
  end

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  logic [3:0] nibble;
  logic       blank;

  always_comb begin
    nibble = bcd[3:0];
    blank  = 1'b0;
    case (idx_nxt)
      2'd0: nibble = bcd[3:0];
      2'd1: begin
        nibble = bcd[7:4];
        blank  = (bcd[15:4] == 12'd0);
      end
      2'd2: begin
        nibble = bcd[11:8];
        blank  = (bcd[15:8] == 8'd0);
      end
      2'd3: begin
        nibble = bcd[15:12];
        blank  = (bcd[15:12] == 4'd0);
      end
      default: nibble = bcd[3:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an   <= 4'b1111;
      sseg <= 7'h7F;
    end else begin
      an   <= dark_nxt ? 4'b1111 : ~(4'b0001 << idx_nxt);
      sseg <= blank ? 7'h7F : seg_code(nibble);
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_time_display.sv
// Directed bench for time_display: conversion latency, scan/blanking, blink bursts
// and asynchronous reset, with hand-computed expectations.
module tb_time_display;

  logic        clk;
  logic        rst;
  logic [11:0] counter;
  logic        time_out;
  logic [15:0] bcd;
  logic        busy;
  logic [3:0]  an;
  logic [6:0]  sseg;
  logic        dp;

  int checks   = 0;
  int failures = 0;

  time_display #(
    .REFRESH_DIV (4),
    .BLINK_DIV   (16),
    .BLINK_PHASES(6)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .counter (counter),
    .time_out(time_out),
    .bcd     (bcd),
    .busy    (busy),
    .an      (an),
    .sseg    (sseg),
    .dp      (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts busy-high samples starting from the capture edge (bounded).
  task automatic conv_wait(output int n);
    n = 0;
    tick(1);
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick(1);
    end
  endtask

  // Watches a full scan and checks the pattern seen on each digit (units first).
  task automatic scan_check(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                            input logic [6:0] e2, input logic [6:0] e3);
    logic [6:0] seg [4];
    logic [3:0] seen;
    int         bad;
    seen = '0;
    bad  = 0;
    for (int i = 0; i < 4; i++) seg[i] = 7'hxx;
    for (int c = 0; c < 20; c++) begin
      case (an)
        4'b1110: begin seg[0] = sseg; seen[0] = 1'b1; end
        4'b1101: begin seg[1] = sseg; seen[1] = 1'b1; end
        4'b1011: begin seg[2] = sseg; seen[2] = 1'b1; end
        4'b0111: begin seg[3] = sseg; seen[3] = 1'b1; end
        default: bad++;
      endcase
      tick(1);
    end
    chk({tag, "_seen"}, {28'd0, seen}, 32'hF);
    chk({tag, "_an_onehot"}, bad, 0);
    chk({tag, "_units"}, {25'd0, seg[0]}, {25'd0, e0});
    chk({tag, "_tens"}, {25'd0, seg[1]}, {25'd0, e1});
    chk({tag, "_hund"}, {25'd0, seg[2]}, {25'd0, e2});
    chk({tag, "_thou"}, {25'd0, seg[3]}, {25'd0, e3});
  endtask

  // Samples an for n cycles after a timeout detect edge; k counts from that edge.
  task automatic blink_run(input string tag, input int n);
    logic exp_dark;
    for (int k = 0; k < n; k++) begin
      exp_dark = (k < 96) && (((k / 16) % 2) == 0);
      chk(tag, {31'd0, an === 4'b1111}, {31'd0, exp_dark});
      tick(1);
    end
  endtask

  task automatic pulse_timeout();
    time_out = 1'b1;
    tick(1);
    time_out = 1'b0;
  endtask

  int         n;
  logic       legal;

  initial begin
    rst      = 1'b0;
    counter  = 12'd0;
    time_out = 1'b0;
    tick(3);
    chk("rst_bcd", {16'd0, bcd}, 32'h0000);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_sseg", {25'd0, sseg}, 32'h7F);
    chk("rst_dp", {31'd0, dp}, 32'd1);

    rst = 1'b1;
    tick(1);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    scan_check("scan0", 7'h40, 7'h7F, 7'h7F, 7'h7F);

    counter = 12'd60;
    conv_wait(n);
    chk("lat60", n, 13);
    chk("bcd60", {16'd0, bcd}, 32'h0060);
    scan_check("scan60", 7'h40, 7'h02, 7'h7F, 7'h7F);

    counter = 12'd4095;
    conv_wait(n);
    chk("lat4095", n, 13);
    chk("bcd4095", {16'd0, bcd}, 32'h4095);
    scan_check("scan4095", 7'h12, 7'h10, 7'h40, 7'h19);

    for (int i = 0; i < 50; i++) begin
      if (i == 0) counter = 12'd60;
      if (i == 3) counter = 12'd59;
      if (i == 6) counter = 12'd58;
      tick(1);
      legal = (bcd === 16'h4095) || (bcd === 16'h0060) ||
              (bcd === 16'h0059) || (bcd === 16'h0058);
      chk("no_tear", {31'd0, legal}, 32'd1);
    end
    chk("bcd58", {16'd0, bcd}, 32'h0058);
    chk("busy58", {31'd0, busy}, 32'd0);
    scan_check("scan58", 7'h00, 7'h12, 7'h7F, 7'h7F);

    pulse_timeout();
    blink_run("blink1", 112);

    pulse_timeout();
    blink_run("blink2a", 40);
    pulse_timeout();
    blink_run("blink2b", 112);

    counter = 12'd4095;
    tick(4);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #2;
    chk("async_bcd", {16'd0, bcd}, 32'h0000);
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_an", {28'd0, an}, 32'hF);
    chk("async_sseg", {25'd0, sseg}, 32'h7F);
    tick(2);
    rst = 1'b1;
    conv_wait(n);
    chk("lat_post_rst", n, 13);
    chk("bcd_post_rst", {16'd0, bcd}, 32'h4095);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
